// File: rtl/bin2rns_pkg.sv
// bin2rns_pkg: shared parameters, FSM state type and helpers for the
// bit-serial binary-to-RNS forward converter.
//   MOD_NUM  - number of residue channels (fixed by the port list)
//   MOD_SIZE - residue width; moduli are MOD_SIZE+1 bits
//   RANGE    - binary input width
//   CNT_W    - width of the bit counter
package bin2rns_pkg;

  localparam int MOD_NUM  = 4;
  localparam int MOD_SIZE = 3;
  localparam int RANGE    = MOD_NUM * MOD_SIZE;
  localparam int CNT_W    = $clog2(RANGE);

  // Largest legal modulus, 2^MOD_SIZE.
  localparam logic [MOD_SIZE:0] MOD_MAX = {1'b1, {MOD_SIZE{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_t;

  // A modulus is usable only in 1..2^MOD_SIZE.
  function automatic logic mod_illegal(input logic [MOD_SIZE:0] m);
    return (m == '0) || (m > MOD_MAX);
  endfunction

endpackage

// File: rtl/bin2rns_mod_reduce.sv
// bin2rns_mod_reduce: one residue channel. Holds a latched modulus and a
// running remainder, reduced one input bit per step (MSB first).
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   load, mod_in   - latch modulus, clear remainder, capture legality
//   step, bit_in   - r <= 2r + bit, minus m when the result reaches m
//   fix, neg       - negate the residue modulo m when the operand was negative
//   residue        - remainder truncated to MOD_SIZE bits
//   illegal        - latched modulus is outside 1..2^MOD_SIZE
module bin2rns_mod_reduce
  import bin2rns_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [MOD_SIZE:0]   mod_in,
  input  logic                step,
  input  logic                bit_in,
  input  logic                fix,
  input  logic                neg,
  output logic [MOD_SIZE-1:0] residue,
  output logic                illegal
);

  logic [MOD_SIZE:0]   m_q, m_d;
  logic [MOD_SIZE+1:0] r_q, r_d;
  logic                illegal_q, illegal_d;
  logic [MOD_SIZE+1:0] r_dbl;
  logic [MOD_SIZE+1:0] m_ext;

  always_comb begin
    m_ext     = {1'b0, m_q};
    // r < m <= 2^MOD_SIZE keeps r's top bit clear, so dropping it is safe.
    r_dbl     = {r_q[MOD_SIZE:0], bit_in};
    m_d       = m_q;
    r_d       = r_q;
    illegal_d = illegal_q;
    if (load) begin
      m_d       = mod_in;
      r_d       = '0;
      illegal_d = mod_illegal(mod_in);
    end else if (step) begin
      r_d = (r_dbl >= m_ext) ? (r_dbl - m_ext) : r_dbl;
    end else if (fix && neg && (r_q != '0)) begin
      r_d = m_ext - r_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q       <= '0;
      r_q       <= '0;
      illegal_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      r_q       <= r_d;
      illegal_q <= illegal_d;
    end
  end

  assign residue = r_q[MOD_SIZE-1:0];
  assign illegal = illegal_q;

endmodule

// File: rtl/bin2rns_seq.sv
// bin2rns_seq: bit-serial binary-to-RNS forward converter, four channels
// in parallel, one conversion at a time with valid/ready on both sides.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid/in_ready     - request handshake (ready only in IDLE)
//   n, mod_1..mod_4       - operand and moduli, latched at accept
//   out_valid/out_ready   - result handshake
//   c0..c3                - residues of n modulo mod_1..mod_4 (0 when err)
//   err                   - at least one modulus outside 1..2^MOD_SIZE
// Build option: BIN2RNS_SIGNED_EN treats n as two's complement; without it
// n is unsigned and FIX is a pass-through cycle (same latency).
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | shifting |n| into all channels, RANGE cycles
// FIX   | sign correction m - r for negative operands
// DONE  | results presented until out_ready
module bin2rns_seq
  import bin2rns_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RANGE-1:0]    n,
  input  logic [MOD_SIZE:0]   mod_1,
  input  logic [MOD_SIZE:0]   mod_2,
  input  logic [MOD_SIZE:0]   mod_3,
  input  logic [MOD_SIZE:0]   mod_4,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MOD_SIZE-1:0] c0,
  output logic [MOD_SIZE-1:0] c1,
  output logic [MOD_SIZE-1:0] c2,
  output logic [MOD_SIZE-1:0] c3,
  output logic                err
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RANGE-1:0]  mag_q, mag_d;
  logic              neg_q, neg_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;

  logic                accept;
  logic [MOD_SIZE:0]   mods    [MOD_NUM];
  logic [MOD_SIZE-1:0] res     [MOD_NUM];
  logic [MOD_NUM-1:0]  illegal;

  assign mods[0] = mod_1;
  assign mods[1] = mod_2;
  assign mods[2] = mod_3;
  assign mods[3] = mod_4;

  assign accept = (state_q == ST_IDLE) && in_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          cnt_d   = CNT_W'(RANGE - 1);
`ifdef BIN2RNS_SIGNED_EN
          neg_d   = n[RANGE-1];
          // -2^(RANGE-1) negates to itself, which is the correct magnitude.
          mag_d   = n[RANGE-1] ? (~n + 1'b1) : n;
`else
          neg_d   = 1'b0;
          mag_d   = n;
`endif
        end
      end
      ST_RUN: begin
        mag_d = mag_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        err_d       = |illegal;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  for (genvar i = 0; i < MOD_NUM; i++) begin : g_ch
    bin2rns_mod_reduce u_ch (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .mod_in  (mods[i]),
      .step    (state_q == ST_RUN),
      .bit_in  (mag_q[RANGE-1]),
      .fix     (state_q == ST_FIX),
      .neg     (neg_q),
      .residue (res[i]),
      .illegal (illegal[i])
    );
  end

  // Held low during reset so no request is taken while the FSM is clearing.
  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign c0 = (out_valid_q && !err_q) ? res[0] : '0;
  assign c1 = (out_valid_q && !err_q) ? res[1] : '0;
  assign c2 = (out_valid_q && !err_q) ? res[2] : '0;
  assign c3 = (out_valid_q && !err_q) ? res[3] : '0;

endmodule
